// File: rtl/fetch_queue.sv
// Instruction prefetch queue between the fetch PC / instruction memory and IF/ID.
// Optional statistics counters are built when FETCH_QUEUE_STATS_EN is defined.
module fetch_queue #(
    parameter int              DEPTH    = 4,
    parameter int              PC_W     = 64,
    parameter int              INST_W   = 32,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [PC_W-1:0]          imem_addr,
    input  logic [INST_W-1:0]        imem_inst,
    input  logic                     redirect,
    input  logic [PC_W-1:0]          redirect_pc,
    input  logic                     deq_ready,
    output logic                     deq_valid,
    output logic [PC_W-1:0]          deq_pc,
    output logic [INST_W-1:0]        deq_inst,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              flush_cnt,
    output logic [15:0]              full_cnt
);

    localparam int              PTR_W      = $clog2(DEPTH);
    localparam int              CNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [PC_W-1:0] PC_STEP    = PC_W'(3'd4);
    localparam logic [PC_W-1:0] ALIGN_MASK = ~(PC_W'(2'b11));

    logic [PC_W-1:0]   pc_mem_r   [DEPTH];
    logic [INST_W-1:0] inst_mem_r [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  count_next_s;
    logic [PC_W-1:0]   fetch_pc_r;
    logic              deq_valid_s;
    logic              deq_fire_s;
    logic              enq_fire_s;
    logic              full_s;

    assign deq_valid_s = (count_r != {CNT_W{1'b0}});
    assign full_s      = (count_r == DEPTH_C);
    assign deq_fire_s  = deq_valid_s & deq_ready;
    // A full queue may still accept a fetch when the head leaves in the same cycle.
    assign enq_fire_s  = ~redirect & (~full_s | deq_fire_s);

    assign imem_addr = fetch_pc_r;
    assign deq_valid = deq_valid_s;
    assign count     = count_r;

    // Head entry presentation; an empty queue reads as zero.
    always_comb begin
        deq_pc   = {PC_W{1'b0}};
        deq_inst = {INST_W{1'b0}};
        if (deq_valid_s) begin
            deq_pc   = pc_mem_r[rd_ptr_r];
            deq_inst = inst_mem_r[rd_ptr_r];
        end else begin
            deq_pc   = {PC_W{1'b0}};
            deq_inst = {INST_W{1'b0}};
        end
    end

    // Occupancy next-state from the enqueue/dequeue pair.
    always_comb begin
        count_next_s = count_r;
        case ({enq_fire_s, deq_fire_s})
            2'b10:   count_next_s = count_r + CNT_W'(1'b1);
            2'b01:   count_next_s = count_r - CNT_W'(1'b1);
            default: count_next_s = count_r;
        endcase
    end

    // Fetch PC, pointers and occupancy; redirect flushes and realigns the target.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_r <= RESET_PC;
            rd_ptr_r   <= {PTR_W{1'b0}};
            wr_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
        end else if (redirect) begin
            fetch_pc_r <= redirect_pc & ALIGN_MASK;
            rd_ptr_r   <= {PTR_W{1'b0}};
            wr_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
        end else begin
            if (enq_fire_s) begin
                fetch_pc_r <= fetch_pc_r + PC_STEP;
                wr_ptr_r   <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (deq_fire_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            count_r <= count_next_s;
        end
    end

    // Entry storage written at the tail on each accepted fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_r[i]   <= {PC_W{1'b0}};
                inst_mem_r[i] <= {INST_W{1'b0}};
            end
        end else if (enq_fire_s) begin
            pc_mem_r[wr_ptr_r]   <= fetch_pc_r;
            inst_mem_r[wr_ptr_r] <= imem_inst;
        end
    end

`ifdef FETCH_QUEUE_STATS_EN
    logic [15:0] flush_cnt_r;
    logic [15:0] full_cnt_r;

    // Saturating redirect and full-stall counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            flush_cnt_r <= 16'h0000;
            full_cnt_r  <= 16'h0000;
        end else begin
            if (redirect && (flush_cnt_r != 16'hFFFF)) begin
                flush_cnt_r <= flush_cnt_r + 16'h0001;
            end
            if (full_s && !deq_fire_s && (full_cnt_r != 16'hFFFF)) begin
                full_cnt_r <= full_cnt_r + 16'h0001;
            end
        end
    end

    assign flush_cnt = flush_cnt_r;
    assign full_cnt  = full_cnt_r;
`else
    assign flush_cnt = 16'h0000;
    assign full_cnt  = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4, RESET_PC=0).
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] imem_addr;
    logic [31:0] imem_inst;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        deq_ready;
    logic        deq_valid;
    logic [63:0] deq_pc;
    logic [31:0] deq_inst;
    logic [2:0]  count;
    logic [15:0] flush_cnt;
    logic [15:0] full_cnt;

    int n_checks = 0;
    int n_errors = 0;

    fetch_queue #(.DEPTH(4), .PC_W(64), .INST_W(32), .RESET_PC(64'h0)) dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_inst(imem_inst),
        .redirect(redirect), .redirect_pc(redirect_pc), .deq_ready(deq_ready),
        .deq_valid(deq_valid), .deq_pc(deq_pc), .deq_inst(deq_inst), .count(count),
        .flush_cnt(flush_cnt), .full_cnt(full_cnt)
    );

    always #5 clk = ~clk;

    // Instruction memory model: content is a fixed function of the address.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'd3) ^ 32'hA5A5_0013;
    endfunction

    assign imem_inst = mem_word(imem_addr);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    logic [63:0] exp_stat_flush;
    logic [63:0] exp_stat_full;

    initial begin
        reset = 1'b1; redirect = 1'b0; redirect_pc = 64'h0; deq_ready = 1'b0;

        // 1: streaming from reset
        deq_ready = 1'b1;
        do_reset();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'(deq_valid), 64'd0);
        chk("rst_pc", deq_pc, 64'd0);
        chk("rst_inst", 64'(deq_inst), 64'd0);
        chk("rst_addr", imem_addr, 64'd0);
        chk("rst_flush", 64'(flush_cnt), 64'd0);
        chk("rst_full", 64'(full_cnt), 64'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("s1_valid", 64'(deq_valid), 64'd1);
            chk("s1_pc", deq_pc, 64'(4 * i));
            chk("s1_inst", 64'(deq_inst), 64'(mem_word(64'(4 * i))));
            chk("s1_count", 64'(count), 64'd1);
        end

        // 2: stall from reset fills to DEPTH and holds
        deq_ready = 1'b0;
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("s2_count", 64'(count), (i < 4) ? 64'(i) : 64'd4);
        end
        chk("s2_addr", imem_addr, 64'd16);
        chk("s2_head", deq_pc, 64'd0);

        // 3: full with one dequeue, then continue streaming without gaps
        deq_ready = 1'b1;
        step();
        chk("s3_count", 64'(count), 64'd4);
        chk("s3_head", deq_pc, 64'd4);
        chk("s3_addr", imem_addr, 64'd20);
        for (int i = 2; i <= 4; i++) begin
            step();
            chk("s3_pc", deq_pc, 64'(4 * i));
            chk("s3_inst", 64'(deq_inst), 64'(mem_word(64'(4 * i))));
        end

        // 4: redirect while count=3
        deq_ready = 1'b0;
        do_reset();
        step(); step(); step();
        chk("s4_pre_count", 64'(count), 64'd3);
        redirect = 1'b1; redirect_pc = 64'h40;
        step();
        redirect = 1'b0;
        chk("s4_count", 64'(count), 64'd0);
        chk("s4_valid", 64'(deq_valid), 64'd0);
        chk("s4_addr", imem_addr, 64'h40);
        step();
        chk("s4_tgt_valid", 64'(deq_valid), 64'd1);
        chk("s4_tgt_pc", deq_pc, 64'h40);
        chk("s4_tgt_inst", 64'(deq_inst), 64'(mem_word(64'h40)));
        redirect = 1'b1; redirect_pc = 64'h43;
        step();
        redirect = 1'b0;
        chk("s4_align", imem_addr, 64'h40);
        chk("s4_align_cnt", 64'(count), 64'd0);

        // 5: reset with count=2 and deq_ready=1 discards entries
        do_reset();
        step(); step();
        chk("s5_pre_count", 64'(count), 64'd2);
        deq_ready = 1'b1;
        do_reset();
        chk("s5_count", 64'(count), 64'd0);
        chk("s5_valid", 64'(deq_valid), 64'd0);
        chk("s5_addr", imem_addr, 64'd0);
        step();
        chk("s5_restart_pc", deq_pc, 64'd0);

        // 6: statistics
`ifdef FETCH_QUEUE_STATS_EN
        exp_stat_flush = 64'd3;
        exp_stat_full  = 64'd10;
`else
        exp_stat_flush = 64'd0;
        exp_stat_full  = 64'd0;
`endif
        deq_ready = 1'b0;
        do_reset();
        redirect = 1'b1; redirect_pc = 64'h100;
        step(); step(); step();
        redirect = 1'b0;
        chk("s6_flush", 64'(flush_cnt), exp_stat_flush);
        step(); step(); step(); step();
        chk("s6_full_pre", 64'(full_cnt), 64'd0);
        chk("s6_full_count", 64'(count), 64'd4);
        for (int i = 0; i < 10; i++) step();
        chk("s6_full", 64'(full_cnt), exp_stat_full);
        chk("s6_hold_addr", imem_addr, 64'h110);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction prefetch buffer between the program counter / instruction memory and the IF/ID pipeline register of the 5-stage RISC-V core.
- Owns the fetch PC and reads the combinational instruction memory once per cycle.
- Stores up to DEPTH {pc, instruction} pairs and presents the oldest pair to IF/ID under a valid/ready handshake.
- Flushes all stored entries and reloads the fetch PC on a taken-branch redirect from EX/MEM.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- PC_W, 64, PC / address width.
- INST_W, 32, instruction width.
- RESET_PC, 0, fetch PC after reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous reset, active-high.
- imem_addr  output  PC_W  address to instruction memory; equals fetch_pc.
- imem_inst  input  INST_W  instruction memory read data, combinational from imem_addr.
- redirect  input  1  taken branch (Branch_EXMEM & zero); flush request.
- redirect_pc  input  PC_W  branch target.
- deq_ready  input  1  IF/ID accepts the head entry this cycle; low means stall.
- deq_valid  output  1  head entry is valid.
- deq_pc  output  PC_W  PC of the head entry.
- deq_inst  output  INST_W  instruction of the head entry.
- count  output  $clog2(DEPTH)+1  current occupancy.
- flush_cnt  output  16  number of redirects taken (optional feature only).
- full_cnt  output  16  number of cycles spent full (optional feature only).

Behaviour:
- Reset (synchronous, when reset=1 at a clock edge):
  - fetch_pc = RESET_PC; read/write pointers = 0; count = 0.
  - deq_valid = 0; deq_pc = 0; deq_inst = 0; stats counters = 0.
  - Reset has priority over every other input. Reset asserted mid-operation discards all entries.
- Derived signals:
  - deq_valid = (count != 0).
  - deq_pc / deq_inst = storage[rd_ptr], driven combinationally from registered storage; they read 0 when count = 0.
  - imem_addr = fetch_pc.
- Dequeue handshake: deq_fire = deq_valid & deq_ready. On deq_fire, rd_ptr advances by 1.
- Enqueue: enq_fire = !redirect & (count < DEPTH | deq_fire).
  - Writes {fetch_pc, imem_inst} at wr_ptr; wr_ptr advances by 1; fetch_pc increments by 4.
  - Enqueue while full is legal only when a dequeue happens in the same cycle; count is then unchanged.
- Count update: +1 on enqueue only, -1 on dequeue only, unchanged on both or neither.
- Pointers wrap modulo DEPTH.
- fetch_pc wraps modulo 2^PC_W.
- When full with no dequeue, fetch_pc holds.
- Redirect (priority over enqueue and dequeue):
  - Next cycle: count = 0; rd_ptr = wr_ptr = 0; fetch_pc = {redirect_pc[PC_W-1:2], 2'b00}.
  - No enqueue or dequeue takes effect in the redirect cycle.
  - deq_valid is 0 the cycle after redirect. The first target instruction becomes valid 2 cycles after the redirect edge.
- Latency: with an empty queue and no stall, an instruction fetched in cycle N is at the head with deq_valid=1 in cycle N+1.
- Empty with deq_ready=1: no state change besides enqueue; there is no combinational bypass.
- Throughput: one instruction per cycle sustained when deq_ready is held at 1.

Optional Feature:
- Macro FETCH_QUEUE_STATS_EN.
- Defined:
  - flush_cnt increments on every redirect cycle.
  - full_cnt increments on every cycle with count == DEPTH and no deq_fire.
  - Both counters are 16-bit and saturate at 16'hFFFF; both clear on reset.
- Undefined: flush_cnt and full_cnt are tied to 0 and no counter registers are built.

Test Plan:
1. Reset then run with deq_ready=1 for 5 cycles:
   - deq_pc sequence is 0, 4, 8, 12.
   - deq_valid is 0 in the first cycle after reset, then 1.
   - deq_inst matches memory contents.
2. deq_ready=0 from reset, DEPTH=4:
   - count rises 1, 2, 3, 4 then holds.
   - imem_addr holds at 16.
   - Raising deq_ready yields deq_pc 0, 4, 8, 12, 16 with no gaps.
3. Full queue with deq_ready=1 for one cycle:
   - count stays 4; head advances from 0 to 4.
   - The entry for pc 16 is written.
4. Redirect=1 with redirect_pc=64'h40 while count=3:
   - Next cycle count=0, deq_valid=0, imem_addr=0x40.
   - The following cycle deq_pc=0x40.
   - redirect_pc=64'h43 gives fetch address 0x40.
5. Reset asserted while count=2 and deq_ready=1:
   - Next cycle count=0, deq_valid=0, imem_addr=RESET_PC.
   - No dequeue of the stale entries occurs.
6. With FETCH_QUEUE_STATS_EN:
   - 3 redirects give flush_cnt=3.
   - 10 stalled full cycles give full_cnt=10.
   - Without the macro, both read 0.
